// File: rtl/tpu_host_loader.sv
// tpu_host_loader
//   Byte-stream command front end for the 2x2 matmul controller. Host
//   commands arrive on a valid/ready byte stream and are turned into the
//   controller's load / memory-load / output-enable strobes. The four 8-bit
//   results (c00, c01, c10, c11) are captured and returned to the host on a
//   valid/ready output byte stream.
//
//   Command byte [7:6]: 00 LOAD_A (+4 data bytes), 01 LOAD_B (+4 data bytes),
//                       10 MEM_LOAD (sel=[2], addr=[1:0]), 11 READ.
//
//   Parameter TIMEOUT : cycles to wait for ctrl_done after READ (1..255).
//
//   Optional build macro OUT_CHECKSUM_EN: when defined, a fifth byte equal to
//   the XOR of the four result bytes is sent after c11.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_byte/in_ready     host -> block byte stream
//   out_valid/out_byte/out_ready  block -> host result stream
//   load_en, load_sel_ab, load_index, load_data   controller element load
//   load_mem, mem_addr                            controller memory load
//   output_en, ctrl_out_data, ctrl_done           controller result path
//   busy              high whenever the FSM is not idle
//   err               one-cycle pulse when a READ times out
module tpu_host_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  input  logic       out_ready,
  output logic       load_en,
  output logic       load_sel_ab,
  output logic [1:0] load_index,
  output logic [7:0] load_data,
  output logic       load_mem,
  output logic [1:0] mem_addr,
  output logic       output_en,
  input  logic [7:0] ctrl_out_data,
  input  logic       ctrl_done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    MEM,
    WAIT,
    DRAIN,
    CAPTURE,
    SEND
  } state_t;

`ifdef OUT_CHECKSUM_EN
  localparam logic [2:0] LAST_PTR = 3'd4;
`else
  localparam logic [2:0] LAST_PTR = 3'd3;
`endif

  // WAIT lasts exactly TIMEOUT cycles; the counter starts at 0 so the last
  // permitted cycle is the one where it holds TIMEOUT-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       sel;
  logic [1:0] idx;
  logic [1:0] addr;
  logic [1:0] cap_k;
  logic [7:0] cnt;
  logic [2:0] ptr;
  logic [7:0] res_buf [4];
  logic [7:0] send_byte;

  // Byte presented during SEND; index 4 is the optional checksum slot.
  always_comb begin
    send_byte = res_buf[ptr[1:0]];
`ifdef OUT_CHECKSUM_EN
    if (ptr == 3'd4) begin
      send_byte = res_buf[0] ^ res_buf[1] ^ res_buf[2] ^ res_buf[3];
    end
`endif
  end

  // Strobes are decoded from the registered state. load_en must follow the
  // host byte in the same cycle, so it also depends on in_valid.
  assign in_ready    = (state == IDLE) || (state == DATA);
  assign load_en     = (state == DATA) && in_valid;
  assign load_mem    = (state == MEM);
  assign load_sel_ab = (load_en || load_mem) ? sel : 1'b0;
  assign load_index  = load_en ? idx : 2'd0;
  assign load_data   = load_en ? in_byte : 8'd0;
  assign mem_addr    = load_mem ? addr : 2'd0;
  assign output_en   = (state == CAPTURE);
  assign out_valid   = (state == SEND);
  assign out_byte    = out_valid ? send_byte : 8'd0;
  assign busy        = (state != IDLE);
  // A done seen on the final WAIT cycle still wins over the timeout.
  assign err         = (state == WAIT) && !ctrl_done && (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      idx   <= 2'd0;
      addr  <= 2'd0;
      cap_k <= 2'd0;
      cnt   <= 8'd0;
      ptr   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        res_buf[i] <= 8'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (in_byte[7:6])
              2'b00, 2'b01: begin
                sel   <= in_byte[6];
                idx   <= 2'd0;
                state <= DATA;
              end
              2'b10: begin
                sel   <= in_byte[2];
                addr  <= in_byte[1:0];
                state <= MEM;
              end
              default: begin
                cnt   <= 8'd0;
                state <= WAIT;
              end
            endcase
          end
        end
        DATA: begin
          if (in_valid) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= IDLE;
            end
          end
        end
        MEM: begin
          state <= IDLE;
        end
        WAIT: begin
          if (ctrl_done) begin
            state <= DRAIN;
          end else if (cnt == TIMEOUT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // Controller needs one cycle in its OUTPUT state before results flow.
        DRAIN: begin
          cap_k <= 2'd0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          res_buf[cap_k] <= ctrl_out_data;
          cap_k          <= cap_k + 2'd1;
          if (cap_k == 2'd3) begin
            ptr   <= 3'd0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (ptr == LAST_PTR) begin
              state <= IDLE;
            end else begin
              ptr <= ptr + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_loader.sv
// tb_tpu_host_loader
//   Directed bench for tpu_host_loader. A small behavioural matmul controller
//   model records load strobes and supplies results while output_en is high.
//   A table of single-cycle vectors covers command decode, and hand-written
//   sequences cover READ, backpressure and timeout.
module tb_tpu_host_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;
  logic       load_en;
  logic       load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] load_data;
  logic       load_mem;
  logic [1:0] mem_addr;
  logic       output_en;
  logic [7:0] ctrl_out_data;
  logic       ctrl_done;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tpu_host_loader #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_byte     (out_byte),
    .out_ready    (out_ready),
    .load_en      (load_en),
    .load_sel_ab  (load_sel_ab),
    .load_index   (load_index),
    .load_data    (load_data),
    .load_mem     (load_mem),
    .mem_addr     (mem_addr),
    .output_en    (output_en),
    .ctrl_out_data(ctrl_out_data),
    .ctrl_done    (ctrl_done),
    .busy         (busy),
    .err          (err)
  );

  // Controller model: stores A/B elements and returns low bytes of A*B in
  // order c00, c01, c10, c11 on successive output_en cycles.
  logic [7:0] a_m [4];
  logic [7:0] b_m [4];
  logic [7:0] res_m [4];
  logic [1:0] oe_k = 2'd0;
  int         oe_total = 0;

  always @(posedge clk) begin
    if (load_en) begin
      if (load_sel_ab) b_m[load_index] <= load_data;
      else             a_m[load_index] <= load_data;
    end
    if (output_en) begin
      oe_k     <= oe_k + 2'd1;
      oe_total <= oe_total + 1;
    end
  end

  always_comb begin
    res_m[0] = a_m[0] * b_m[0] + a_m[1] * b_m[2];
    res_m[1] = a_m[0] * b_m[1] + a_m[1] * b_m[3];
    res_m[2] = a_m[2] * b_m[0] + a_m[3] * b_m[2];
    res_m[3] = a_m[2] * b_m[1] + a_m[3] * b_m[3];
  end

  assign ctrl_out_data = output_en ? res_m[oe_k] : 8'h00;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] b;
    logic       rdy;
    logic       le;
    logic       sel;
    logic [1:0] idx;
    logic [7:0] data;
    logic       lm;
    logic [1:0] addr;
    logic       busy;
  } vec_t;

  function automatic vec_t mkvec(input logic r, input logic v, input logic [7:0] b,
                                 input logic rdy, input logic le, input logic sel,
                                 input logic [1:0] idx, input logic [7:0] data,
                                 input logic lm, input logic [1:0] addr,
                                 input logic bsy);
    vec_t t;
    t.rst = r; t.v = v; t.b = b; t.rdy = rdy; t.le = le; t.sel = sel;
    t.idx = idx; t.data = data; t.lm = lm; t.addr = addr; t.busy = bsy;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t t, input int i);
    @(negedge clk);
    rst = t.rst; in_valid = t.v; in_byte = t.b;
    #1;
    checkOutput($sformatf("vec%0d in_ready", i), in_ready, t.rdy);
    checkOutput($sformatf("vec%0d load_en", i), load_en, t.le);
    checkOutput($sformatf("vec%0d load_mem", i), load_mem, t.lm);
    checkOutput($sformatf("vec%0d busy", i), busy, t.busy);
    checkOutput($sformatf("vec%0d oe/ov/err", i), {output_en, out_valid, err}, 3'b000);
    if (t.le) begin
      checkOutput($sformatf("vec%0d load_sel_ab", i), load_sel_ab, t.sel);
      checkOutput($sformatf("vec%0d load_index", i), load_index, t.idx);
      checkOutput($sformatf("vec%0d load_data", i), load_data, t.data);
    end
    if (t.lm) begin
      checkOutput($sformatf("vec%0d mem sel", i), load_sel_ab, t.sel);
      checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, t.addr);
    end
  endtask

  // Presents one byte and holds it until accepted (bounded).
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_byte = b;
    #1;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) checkOutput("sendByte in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic runRead(input int done_delay, input int hold_cycles, input string tag);
    logic [7:0] got [$];
    logic [7:0] want [5];
    int nexp;
    int oe_start = oe_total;
    int held = 0;
    int overlap = 0;
    int err_seen = 0;
    bit finished = 1'b0;
    want[0] = 8'd19; want[1] = 8'd22; want[2] = 8'd43; want[3] = 8'd50; want[4] = 8'd28;
`ifdef OUT_CHECKSUM_EN
    nexp = 5;
`else
    nexp = 4;
`endif
    sendByte(8'hC0);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      ctrl_done = (cyc >= done_delay);
      out_ready = (held >= hold_cycles);
      #1;
      if (out_valid && in_ready) overlap++;
      if (err) err_seen++;
      if (out_valid) begin
        if (out_ready) got.push_back(out_byte);
        else begin
          checkOutput($sformatf("%s held byte %0d", tag, held), out_byte, want[0]);
          held++;
        end
      end
      if (!busy && (got.size() > 0 || err_seen > 0)) finished = 1'b1;
      if (!finished) @(negedge clk);
    end
    ctrl_done = 1'b0;
    checkOutput({tag, " completed"}, finished, 1);
    checkOutput({tag, " busy after"}, busy, 0);
    checkOutput({tag, " byte count"}, got.size(), nexp);
    for (int i = 0; i < got.size() && i < nexp; i++)
      checkOutput($sformatf("%s byte%0d", tag, i), got[i], want[i]);
    checkOutput({tag, " output_en cycles"}, oe_total - oe_start, 4);
    checkOutput({tag, " out_valid with in_ready"}, overlap, 0);
    checkOutput({tag, " err"}, err_seen, 0);
    checkOutput({tag, " held cycles"}, held, hold_cycles);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [$];
    int first_err = 0;
    int err_cnt = 0;
    int ov_cnt = 0;
    int rdy_early = 0;

    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0; ctrl_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset strobes", {load_en, load_mem, output_en, out_valid, err, busy}, 6'b0);
    checkOutput("reset data outs", {out_byte, load_data, load_index, mem_addr, load_sel_ab}, 0);

    //                 rst v  byte  rdy le sel idx data  lm addr busy
    vecs.push_back(mkvec(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0)); // LOAD_A
    vecs.push_back(mkvec(0, 1, 8'h01, 1, 1, 0, 0, 8'h01, 0, 0, 1));
    vecs.push_back(mkvec(0, 1, 8'h02, 1, 1, 0, 1, 8'h02, 0, 0, 1));
    vecs.push_back(mkvec(0, 1, 8'h03, 1, 1, 0, 2, 8'h03, 0, 0, 1));
    vecs.push_back(mkvec(0, 1, 8'h04, 1, 1, 0, 3, 8'h04, 0, 0, 1));
    vecs.push_back(mkvec(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkvec(0, 1, 8'h86, 1, 0, 0, 0, 8'h00, 0, 0, 0)); // MEM_LOAD
    vecs.push_back(mkvec(0, 1, 8'h00, 0, 0, 1, 0, 8'h00, 1, 2, 1)); // byte held off
    vecs.push_back(mkvec(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0)); // now LOAD_A
    vecs.push_back(mkvec(0, 1, 8'h0A, 1, 1, 0, 0, 8'h0A, 0, 0, 1));
    vecs.push_back(mkvec(0, 1, 8'h0B, 1, 1, 0, 1, 8'h0B, 0, 0, 1));
    vecs.push_back(mkvec(0, 1, 8'h0C, 1, 1, 0, 2, 8'h0C, 0, 0, 1));
    vecs.push_back(mkvec(0, 1, 8'h0D, 1, 1, 0, 3, 8'h0D, 0, 0, 1));
    vecs.push_back(mkvec(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkvec(0, 1, 8'h40, 1, 0, 0, 0, 8'h00, 0, 0, 0)); // LOAD_B
    vecs.push_back(mkvec(0, 1, 8'h05, 1, 1, 1, 0, 8'h05, 0, 0, 1));
    vecs.push_back(mkvec(0, 1, 8'h06, 1, 1, 1, 1, 8'h06, 0, 0, 1));
    vecs.push_back(mkvec(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 1)); // reset mid-DATA
    vecs.push_back(mkvec(0, 1, 8'h86, 1, 0, 0, 0, 8'h00, 0, 0, 0)); // decoded as command
    vecs.push_back(mkvec(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 2, 1));
    vecs.push_back(mkvec(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Full matmul: A = 1,2,3,4  B = 5,6,7,8
    sendByte(8'h00);
    for (int i = 1; i <= 4; i++) sendByte(8'(i));
    sendByte(8'h40);
    for (int i = 5; i <= 8; i++) sendByte(8'(i));
    runRead(3, 0, "read");

    // Done already on first WAIT cycle, plus output backpressure
    runRead(0, 5, "bp read");

    // Timeout with ctrl_done held low: err on the 16th cycle after acceptance
    ctrl_done = 1'b0;
    sendByte(8'hC0);
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (err) begin
        err_cnt++;
        if (first_err == 0) first_err = n;
      end
      if (out_valid) ov_cnt++;
      if (n <= 16 && in_ready) rdy_early++;
      if (n == 17) checkOutput("timeout in_ready after", in_ready, 1);
      @(negedge clk);
    end
    checkOutput("timeout err count", err_cnt, 1);
    checkOutput("timeout err cycle", first_err, 16);
    checkOutput("timeout out_valid", ov_cnt, 0);
    checkOutput("timeout in_ready during wait", rdy_early, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_host_loader.md
Name: tpu_host_loader

Overview:
- Byte-stream command front end sitting directly upstream of the 2x2 matmul controller.
- Parses host commands arriving on a valid/ready byte interface and drives the controller's load, memory-load and output-enable pins.
- Captures the four 8-bit results and returns them to the host on a valid/ready output byte stream.

Parameters:
- TIMEOUT, 255, max cycles to wait for ctrl_done after a READ command before aborting (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  host command/data byte valid
- in_byte  in  8  host byte
- in_ready  out  1  block accepts in_byte this cycle
- out_valid  out  1  result byte valid
- out_byte  out  8  result byte
- out_ready  in  1  host accepts out_byte
- load_en  out  1  controller load strobe
- load_sel_ab  out  1  0=A, 1=B
- load_index  out  2  element index
- load_data  out  8  element value (to controller in_data)
- load_mem  out  1  controller memory-load strobe
- mem_addr  out  2  controller memory address
- output_en  out  1  controller output enable
- ctrl_out_data  in  8  controller out_data
- ctrl_done  in  1  controller done
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on READ timeout

Behaviour:
- Byte transfer occurs on a cycle where in_valid && in_ready. The output side transfers on out_valid && out_ready.
- Command byte encoding:
  - [7:6]=00: LOAD_A, followed by 4 data bytes.
  - [7:6]=01: LOAD_B, followed by 4 data bytes.
  - [7:6]=10: MEM_LOAD, with sel=[2] and addr=[1:0].
  - [7:6]=11: READ.
  - Unused bits are ignored.
- States: IDLE, DATA, MEM, WAIT, DRAIN, CAPTURE, SEND.
- IDLE: in_ready=1.
  - LOAD_A/LOAD_B: latch sel and clear idx=0, then go to DATA.
  - MEM_LOAD: go to MEM.
  - READ: clear the timeout counter and go to WAIT.
- DATA: in_ready=1.
  - Each accepted byte produces a combinational one-cycle pulse: load_en=1, load_sel_ab=sel, load_index=idx, load_data=in_byte. idx then increments.
  - After the byte with idx=3, go to IDLE. The next byte after that is decoded as a command.
- MEM: in_ready=0 for exactly one cycle, with load_mem=1, load_sel_ab=sel, mem_addr=addr. Then go to IDLE.
- WAIT: in_ready=0.
  - Counter increments each cycle.
  - If ctrl_done is sampled 1, go to DRAIN.
  - If the counter reaches TIMEOUT first, pulse err for 1 cycle and go to IDLE; no output bytes are produced.
- DRAIN: one cycle with output_en=0, so the controller is in its OUTPUT state. Then go to CAPTURE.
- CAPTURE: output_en=1 for exactly 4 consecutive cycles.
  - In cycle k (k=0..3), ctrl_out_data is registered into buf[k].
  - Then go to SEND.
- SEND:
  - out_valid=1 and out_byte=buf[ptr], starting at ptr=0.
  - ptr advances on each transfer.
  - After buf[3] transfers, go to IDLE.
  - While out_ready=0, out_byte and out_valid hold stable.
- Outputs in IDLE: load_en, load_mem, output_en, out_valid, err and busy are 0.
- Reset values: all outputs 0 except in_ready. Because in_ready=1 in IDLE, it is 1 on the cycle after reset. Internal state returns to IDLE with idx, ptr, counter and buf cleared.
- Reset mid-operation aborts any partial LOAD, READ or SEND. Partially loaded controller state is the controller's own concern.
- Host protocol rule: LOAD/MEM_LOAD commands are issued only while the controller is idle. The block does not check this.
- out_valid never coincides with in_ready=1.
- ctrl_done=1 already on the first WAIT cycle still takes the DRAIN path.
- Result bytes are controller low bytes, returned in order c00, c01, c10, c11.

Optional Feature:
- Macro: OUT_CHECKSUM_EN.
  - Defined: SEND emits a 5th byte equal to buf[0]^buf[1]^buf[2]^buf[3] after buf[3], with the same handshake. IDLE follows the checksum transfer.
  - Undefined: exactly 4 result bytes, and no checksum logic is present.

Test Plan:
- LOAD_A then data: send 0x00,1,2,3,4 -> four load_en pulses with sel=0, index 0,1,2,3, data 1,2,3,4; then in IDLE.
- Full matmul: A=1,2,3,4 (0x00...), B=5,6,7,8 (0x40...), then READ 0xC0 with out_ready=1 -> output_en high for exactly 4 cycles, out bytes 19,22,43,50, busy low afterwards. With OUT_CHECKSUM_EN, a 5th byte 28 follows.
- MEM_LOAD: send 0x86 -> exactly one cycle of load_mem=1 with load_sel_ab=1, mem_addr=2, in_ready=0 that cycle, load_en=0.
- Timeout: TIMEOUT=16, READ 0xC0 with ctrl_done held 0 -> err pulses once 16 cycles after the command is accepted, in_ready returns 1, out_valid never asserts.
- Backpressure: during SEND hold out_ready=0 for 5 cycles after the first valid -> out_byte stays 19 and out_valid stays 1. Releasing out_ready yields 19,22,43,50 with no loss or duplication.
- Reset mid-DATA: after 0x40,5,6, assert rst for 1 cycle -> all strobes 0 and in_ready=1 on the cycle after. The next byte 0x86 is decoded as MEM_LOAD, not as data.
